// File: rtl/abs_diff_approx_pipe_if.sv
// Valid/ready bus for the abs_diff_approx_pipe unit: operand channel in, result channel out.
// The producer/consumer side uses master; the unit uses slave.
interface abs_diff_approx_pipe_if #(
  parameter int WIDTH = 8
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             in_mode;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_diff;
  logic [WIDTH-1:0] out_err;
  logic             out_viol;

  modport master (
    output in_valid,
    output in_a,
    output in_b,
    output in_mode,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_diff,
    input  out_err,
    input  out_viol
  );

  modport slave (
    input  in_valid,
    input  in_a,
    input  in_b,
    input  in_mode,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_diff,
    output out_err,
    output out_viol
  );

endinterface

// File: rtl/abs_diff_approx_pipe.sv
// Two-stage |a-b| unit with per-transaction exact/approximate (LSB-truncated) mode,
// per-result error against an exact reference, and running violation statistics.
module abs_diff_approx_pipe #(
  parameter int WIDTH      = 8,
  parameter int APPROX_LSB = 2,
  parameter int ET         = 2,
  parameter int CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  abs_diff_approx_pipe_if.slave bus,
  input  logic                  clr_stats,
  output logic [CNT_W-1:0]      viol_count,
  output logic [WIDTH-1:0]      max_err
);

  localparam logic [WIDTH-1:0] LSB_MASK = {WIDTH{1'b1}} << APPROX_LSB;
  localparam logic [WIDTH-1:0] ET_W     = WIDTH'(ET);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  function automatic logic [WIDTH-1:0] abs_sub(input logic [WIDTH-1:0] x,
                                               input logic [WIDTH-1:0] y);
    logic [WIDTH-1:0] r;
    if (x >= y) begin
      r = x - y;
    end else begin
      r = y - x;
    end
    return r;
  endfunction

  logic             s1_v_q,    s1_v_d;
  logic [WIDTH-1:0] s1_a_q,    s1_a_d;
  logic [WIDTH-1:0] s1_b_q,    s1_b_d;
  logic             s1_mode_q, s1_mode_d;
  logic             s2_v_q,    s2_v_d;
  logic [WIDTH-1:0] s2_diff_q, s2_diff_d;
  logic [WIDTH-1:0] s2_err_q,  s2_err_d;
  logic             s2_viol_q, s2_viol_d;
  logic [CNT_W-1:0] viol_q,    viol_d;
  logic [WIDTH-1:0] max_q,     max_d;

  logic             s2_load_s;
  logic             s1_load_s;
  logic             out_fire_s;
  logic [WIDTH-1:0] exact_s;
  logic [WIDTH-1:0] approx_s;
  logic [WIDTH-1:0] diff_s;
  logic [WIDTH-1:0] err_s;
  logic             viol_s;

  // Handshake: a stage may load when it is empty or its content moves on this edge.
  always_comb begin
    out_fire_s = s2_v_q && bus.out_ready;
    s2_load_s  = !s2_v_q || bus.out_ready;
    s1_load_s  = !s1_v_q || s2_load_s;
  end

  // Exact and truncated datapaths side by side so every result carries its own error.
  always_comb begin
    exact_s  = abs_sub(s1_a_q, s1_b_q);
    approx_s = abs_sub(s1_a_q & LSB_MASK, s1_b_q & LSB_MASK);
    if (s1_mode_q) begin
      diff_s = approx_s;
    end else begin
      diff_s = exact_s;
    end
    err_s  = abs_sub(diff_s, exact_s);
    viol_s = err_s > ET_W;
  end

  // Stage 1 next state: operands and mode captured together on an input transfer.
  always_comb begin
    s1_v_d    = s1_v_q;
    s1_a_d    = s1_a_q;
    s1_b_d    = s1_b_q;
    s1_mode_d = s1_mode_q;
    if (s1_load_s) begin
      s1_v_d = bus.in_valid;
      if (bus.in_valid) begin
        s1_a_d    = bus.in_a;
        s1_b_d    = bus.in_b;
        s1_mode_d = bus.in_mode;
      end else begin
        s1_a_d    = s1_a_q;
        s1_b_d    = s1_b_q;
        s1_mode_d = s1_mode_q;
      end
    end else begin
      s1_v_d = s1_v_q;
    end
  end

  // Stage 2 next state: result fields hold while the consumer stalls.
  always_comb begin
    s2_v_d    = s2_v_q;
    s2_diff_d = s2_diff_q;
    s2_err_d  = s2_err_q;
    s2_viol_d = s2_viol_q;
    if (s2_load_s) begin
      s2_v_d = s1_v_q;
      if (s1_v_q) begin
        s2_diff_d = diff_s;
        s2_err_d  = err_s;
        s2_viol_d = viol_s;
      end else begin
        s2_diff_d = s2_diff_q;
        s2_err_d  = s2_err_q;
        s2_viol_d = s2_viol_q;
      end
    end else begin
      s2_v_d = s2_v_q;
    end
  end

  // Statistics next state: clear wins over a same-cycle transfer; counter saturates.
  always_comb begin
    viol_d = viol_q;
    max_d  = max_q;
    if (clr_stats) begin
      viol_d = {CNT_W{1'b0}};
      max_d  = {WIDTH{1'b0}};
    end else if (out_fire_s) begin
      if (s2_viol_q && (viol_q != CNT_MAX)) begin
        viol_d = viol_q + CNT_ONE;
      end else begin
        viol_d = viol_q;
      end
      if (s2_err_q > max_q) begin
        max_d = s2_err_q;
      end else begin
        max_d = max_q;
      end
    end else begin
      viol_d = viol_q;
      max_d  = max_q;
    end
  end

  // Stage 1 registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_v_q    <= 1'b0;
      s1_a_q    <= {WIDTH{1'b0}};
      s1_b_q    <= {WIDTH{1'b0}};
      s1_mode_q <= 1'b0;
    end else begin
      s1_v_q    <= s1_v_d;
      s1_a_q    <= s1_a_d;
      s1_b_q    <= s1_b_d;
      s1_mode_q <= s1_mode_d;
    end
  end

  // Stage 2 registers, which directly drive the result channel.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s2_v_q    <= 1'b0;
      s2_diff_q <= {WIDTH{1'b0}};
      s2_err_q  <= {WIDTH{1'b0}};
      s2_viol_q <= 1'b0;
    end else begin
      s2_v_q    <= s2_v_d;
      s2_diff_q <= s2_diff_d;
      s2_err_q  <= s2_err_d;
      s2_viol_q <= s2_viol_d;
    end
  end

  // Statistics registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      viol_q <= {CNT_W{1'b0}};
      max_q  <= {WIDTH{1'b0}};
    end else begin
      viol_q <= viol_d;
      max_q  <= max_d;
    end
  end

  assign bus.in_ready  = s1_load_s;
  assign bus.out_valid = s2_v_q;
  assign bus.out_diff  = s2_diff_q;
  assign bus.out_err   = s2_err_q;
  assign bus.out_viol  = s2_viol_q;
  assign viol_count    = viol_q;
  assign max_err       = max_q;

endmodule

// File: tb/tb_abs_diff_approx_pipe.sv
// Directed, table-driven bench for abs_diff_approx_pipe (APPROX_LSB=2, ET=2, CNT_W=2
// so counter saturation is reachable), plus hand-written stall, clear and reset sequences.
module tb_abs_diff_approx_pipe;

  localparam int WIDTH      = 8;
  localparam int APPROX_LSB = 2;
  localparam int ET         = 2;
  localparam int CNT_W      = 2;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       mode;
    logic [7:0] diff;
    logic [7:0] err;
    logic       viol;
  } vec_t;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             clr_stats = 1'b0;
  logic [CNT_W-1:0] viol_count;
  logic [WIDTH-1:0] max_err;

  int n_checks = 0;
  int n_errors = 0;

  abs_diff_approx_pipe_if #(.WIDTH(WIDTH)) bus ();

  abs_diff_approx_pipe #(
    .WIDTH(WIDTH), .APPROX_LSB(APPROX_LSB), .ET(ET), .CNT_W(CNT_W)
  ) u_dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus.slave),
    .clr_stats(clr_stats),
    .viol_count(viol_count),
    .max_err(max_err)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // One unstalled transaction; returns the result and checks the 2-cycle latency.
  task automatic xfer(input logic [7:0] a, input logic [7:0] b, input logic m,
                      output logic [7:0] d, output logic [7:0] e, output logic v);
    int w;
    bus.in_a      = a;
    bus.in_b      = b;
    bus.in_mode   = m;
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    w = 0;
    while (!bus.out_valid && w < 8) begin
      @(posedge clk); #1;
      w++;
    end
    chk("latency", w, 1);
    d = bus.out_diff;
    e = bus.out_err;
    v = bus.out_viol;
    @(posedge clk); #1;
  endtask

  vec_t       vecs[14];
  logic [7:0] got_d, got_e;
  logic       got_v;
  logic [1:0] exp_vc;
  logic [7:0] exp_me;
  logic [1:0] sat_exp[5];
  logic [7:0] vals[4];
  logic [7:0] rx[$];
  int         rxc[$];
  int         idx;
  int         stale;
  logic       in_f;

  initial begin
    vecs[0]  = '{8'd200, 8'd55,  1'b0, 8'd145, 8'd0, 1'b0};
    vecs[1]  = '{8'd7,   8'd2,   1'b1, 8'd4,   8'd1, 1'b0};
    vecs[2]  = '{8'd3,   8'd0,   1'b1, 8'd0,   8'd3, 1'b1};
    vecs[3]  = '{8'd200, 8'd55,  1'b1, 8'd148, 8'd3, 1'b1};
    vecs[4]  = '{8'd55,  8'd200, 1'b1, 8'd148, 8'd3, 1'b1};
    vecs[5]  = '{8'd0,   8'd255, 1'b0, 8'd255, 8'd0, 1'b0};
    vecs[6]  = '{8'd255, 8'd0,   1'b1, 8'd252, 8'd3, 1'b1};
    vecs[7]  = '{8'd13,  8'd14,  1'b1, 8'd0,   8'd1, 1'b0};
    vecs[8]  = '{8'd100, 8'd100, 1'b1, 8'd0,   8'd0, 1'b0};
    vecs[9]  = '{8'd6,   8'd1,   1'b1, 8'd4,   8'd1, 1'b0};
    vecs[10] = '{8'd1,   8'd6,   1'b1, 8'd4,   8'd1, 1'b0};
    vecs[11] = '{8'd8,   8'd7,   1'b1, 8'd4,   8'd3, 1'b1};
    vecs[12] = '{8'd16,  8'd13,  1'b1, 8'd4,   8'd1, 1'b0};
    vecs[13] = '{8'd130, 8'd2,   1'b1, 8'd128, 8'd0, 1'b0};
    sat_exp  = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
    vals     = '{8'd10, 8'd20, 8'd30, 8'd40};

    bus.in_valid  = 1'b0;
    bus.in_a      = 8'd0;
    bus.in_b      = 8'd0;
    bus.in_mode   = 1'b0;
    bus.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_in_ready", bus.in_ready, 1);
    chk("rst_out_diff", bus.out_diff, 0);
    chk("rst_out_err", bus.out_err, 0);
    chk("rst_out_viol", bus.out_viol, 0);
    chk("rst_viol_count", viol_count, 0);
    chk("rst_max_err", max_err, 0);

    // Vector table with a running statistics model.
    exp_vc = 2'd0;
    exp_me = 8'd0;
    for (int i = 0; i < 14; i++) begin
      xfer(vecs[i].a, vecs[i].b, vecs[i].mode, got_d, got_e, got_v);
      if (vecs[i].viol && exp_vc != 2'd3) exp_vc = exp_vc + 2'd1;
      if (vecs[i].err > exp_me) exp_me = vecs[i].err;
      chk($sformatf("vec%0d_diff", i), got_d, vecs[i].diff);
      chk($sformatf("vec%0d_err", i), got_e, vecs[i].err);
      chk($sformatf("vec%0d_viol", i), got_v, vecs[i].viol);
      chk($sformatf("vec%0d_viol_count", i), viol_count, exp_vc);
      chk($sformatf("vec%0d_max_err", i), max_err, exp_me);
      chk($sformatf("vec%0d_no_dup", i), bus.out_valid, 0);
    end

    // Saturation of the 2-bit violation counter.
    clr_stats = 1'b1;
    @(posedge clk); #1;
    clr_stats = 1'b0;
    chk("clr_idle_viol_count", viol_count, 0);
    chk("clr_idle_max_err", max_err, 0);
    for (int i = 0; i < 5; i++) begin
      xfer(8'd3, 8'd0, 1'b1, got_d, got_e, got_v);
      chk($sformatf("sat%0d_viol_count", i), viol_count, sat_exp[i]);
    end

    // Clear coinciding with a violating output transfer.
    bus.out_ready = 1'b0;
    bus.in_a      = 8'd3;
    bus.in_b      = 8'd0;
    bus.in_mode   = 1'b1;
    bus.in_valid  = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    @(posedge clk); #1;
    chk("clr_held_valid", bus.out_valid, 1);
    chk("clr_held_viol", bus.out_viol, 1);
    bus.out_ready = 1'b1;
    clr_stats     = 1'b1;
    @(posedge clk); #1;
    clr_stats = 1'b0;
    chk("clr_xfer_viol_count", viol_count, 0);
    chk("clr_xfer_max_err", max_err, 0);
    chk("clr_xfer_drained", bus.out_valid, 0);
    xfer(8'd3, 8'd0, 1'b1, got_d, got_e, got_v);
    chk("clr_next_viol_count", viol_count, 1);
    chk("clr_next_max_err", max_err, 3);

    // Backpressure: 6 stalled cycles, then release and collect in order.
    bus.in_b    = 8'd0;
    bus.in_mode = 1'b0;
    idx = 0;
    for (int cyc = 0; cyc < 16; cyc++) begin
      bus.out_ready = (cyc >= 6);
      bus.in_valid  = (idx < 4);
      bus.in_a      = (idx < 4) ? vals[idx] : 8'd0;
      #1;
      in_f = bus.in_valid && bus.in_ready;
      if (bus.out_valid && !bus.out_ready) begin
        chk("stall_hold_diff", bus.out_diff, 10);
        chk("stall_hold_err", bus.out_err, 0);
      end
      if (bus.out_valid && bus.out_ready) begin
        rx.push_back(bus.out_diff);
        rxc.push_back(cyc);
      end
      @(posedge clk); #1;
      if (in_f) idx++;
      if (cyc == 5) begin
        chk("stall_accepted", idx, 2);
        chk("stall_in_ready", bus.in_ready, 0);
      end
    end
    bus.in_valid = 1'b0;
    chk("bp_count", rx.size(), 4);
    if (rx.size() == 4) begin
      for (int i = 0; i < 4; i++) chk($sformatf("bp_order%0d", i), rx[i], vals[i]);
      chk("bp_no_gap", rxc[3] - rxc[0], 3);
    end
    chk("bp_viol_count", viol_count, 1);

    // Reset with both stages full and the consumer stalled.
    bus.out_ready = 1'b0;
    bus.in_mode   = 1'b0;
    bus.in_a      = 8'd50;
    bus.in_valid  = 1'b1;
    @(posedge clk); #1;
    bus.in_a = 8'd60;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    chk("full_in_ready", bus.in_ready, 0);
    chk("full_out_valid", bus.out_valid, 1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk("mid_rst_out_valid", bus.out_valid, 0);
    chk("mid_rst_in_ready", bus.in_ready, 1);
    chk("mid_rst_viol_count", viol_count, 0);
    chk("mid_rst_max_err", max_err, 0);
    chk("mid_rst_out_diff", bus.out_diff, 0);
    bus.out_ready = 1'b1;
    stale = 0;
    repeat (6) begin
      @(posedge clk); #1;
      if (bus.out_valid) stale++;
    end
    chk("mid_rst_no_stale", stale, 0);
    xfer(8'd9, 8'd4, 1'b1, got_d, got_e, got_v);
    chk("post_rst_diff", got_d, 4);
    chk("post_rst_err", got_e, 1);
    chk("post_rst_max_err", max_err, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/abs_diff_approx_pipe.md
Name: abs_diff_approx_pipe

Overview:
- Parametrised, pipelined absolute-difference unit |a-b| with a per-transaction exact/approximate mode select.
- Approximate mode truncates APPROX_LSB operand LSBs, the same error-bounded trade-off as the team's approximated abs_diff netlists.
- Runs an exact datapath in parallel, reports per-result error against threshold ET, and keeps running error statistics.
- Sits between a valid/ready producer and consumer in the approximate-datapath evaluation harness.

Parameters:
- WIDTH, 8, operand and result width (unsigned).
- APPROX_LSB, 2, LSBs zeroed on both operands in approximate mode; 0 <= APPROX_LSB < WIDTH.
- ET, 2, error threshold; a result with error > ET is a violation.
- CNT_W, 16, width of the violation counter.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst_n  in  1  synchronous active-low reset.
- in_valid  in  1  operand transaction valid.
- in_ready  out  1  unit can accept an operand.
- in_a  in  WIDTH  operand a (unsigned).
- in_b  in  WIDTH  operand b (unsigned).
- in_mode  in  1  0 = exact, 1 = approximate; sampled with the operands.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- out_diff  out  WIDTH  result: exact or approximate per the sampled mode.
- out_err  out  WIDTH  |exact - out_diff| for this result.
- out_viol  out  1  out_err > ET for this result.
- clr_stats  in  1  synchronous clear of the statistics.
- viol_count  out  CNT_W  saturating count of accepted violating results.
- max_err  out  WIDTH  maximum out_err over accepted results.

Behaviour:
- Reset (rst_n=0 at a rising edge): both stage valids clear. out_valid=0, out_diff=0, out_err=0, out_viol=0, viol_count=0, max_err=0. in_ready=1 from the first cycle after reset.
- Reset mid-operation discards all in-flight transactions; nothing is emitted for them.
- Accept: an input transfer occurs when in_valid && in_ready. An output transfer occurs when out_valid && out_ready.
- Pipeline: two stages.
  - S1 registers a, b and mode.
  - S2 registers diff, err and viol.
  - Latency is 2 cycles from input transfer to out_valid when unstalled. Throughput is 1 per cycle.
- Stall rules:
  - S2 loads when S2 is empty or an output transfer occurs.
  - S1 loads when S1 is empty or S1 advances into S2.
  - in_ready = !s1_v || !s2_v || out_ready. A combinational path from out_ready to in_ready is permitted.
  - No transaction is dropped or duplicated; order is preserved.
  - out_diff, out_err and out_viol stay stable while out_valid && !out_ready.
- Arithmetic (computed in S1 to S2, all unsigned, WIDTH bits, no overflow possible):
  - exact = (a >= b) ? a-b : b-a.
  - at, bt = a, b with bits [APPROX_LSB-1:0] forced to 0.
  - approx = |at - bt|.
  - diff = mode ? approx : exact.
  - err = (diff >= exact) ? diff-exact : exact-diff.
  - viol = err > ET.
  - In exact mode err = 0 always. With APPROX_LSB = 0 the modes are identical.
- Statistics (update only on output transfer):
  - If out_viol, viol_count increments, saturating at 2^CNT_W-1 (no wrap).
  - max_err = max(max_err, out_err).
  - clr_stats=1 zeroes both on that edge and has priority: a transfer in the same cycle is not counted. The pipeline is unaffected by clr_stats.
- Mode is per transaction. Changing in_mode between transfers never affects transactions already accepted.

Test Plan:
- Exact mode, unstalled: a=200, b=55, mode=0, out_ready=1 -> 2 cycles later out_diff=145, out_err=0, out_viol=0; stats unchanged.
- Approx mode, defaults (APPROX_LSB=2, ET=2):
  - a=7, b=2 -> out_diff=4, out_err=1, out_viol=0.
  - Then a=3, b=0 -> out_diff=0, out_err=3, out_viol=1, viol_count=1, max_err=3.
- Backpressure: out_ready=0 for 6 cycles while in_valid=1 with a=10,20,30,40 and b=0 -> exactly 2 accepted, then in_ready=0. After release, results emerge in order 10,20,30,40 with no gaps or duplicates, and outputs stay stable during the stall.
- Saturation: CNT_W=2, five violating transfers (a=3, b=0, mode=1) -> viol_count reads 1,2,3,3,3.
- clr_stats asserted in the same cycle as a violating output transfer -> viol_count=0 and max_err=0 on the next cycle; the next violating transfer gives viol_count=1.
- Reset mid-operation: both stages full and out_ready=0, pulse rst_n=0 for one edge -> out_valid=0 and stats=0 the next cycle, in_ready=1, and no stale result ever appears.
